// File: rtl/ysyx_pkg.sv
// Shared FSM encoding and default geometry for the IFU L1 instruction cache.
// Pure declarations; no logic, no latency, no flow control.
package ysyx_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int SET_LEN_DEF  = 3;
  localparam int LINE_LEN_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AR     = 2'd1,
    REFILL = 2'd2,
    RESP   = 2'd3
  } l1i_state_e;

endpackage

// File: rtl/ysyx_l1i_array.sv
// Tag/data/valid storage: combinational read port, registered write port, flash-clear of valid.
// Writes land on the next clk edge; flush wins over a same-cycle valid write; no backpressure.
module ysyx_l1i_array
  import ysyx_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TAG_W    = ADDR_W_DEF - SET_LEN_DEF - LINE_LEN_DEF - 2,
  parameter int SET_LEN  = SET_LEN_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SET_LEN-1:0]  rd_index,
  input  logic [LINE_LEN-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [SET_LEN-1:0]  wr_index,
  input  logic [LINE_LEN-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                tag_we,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                wr_valid
);

  localparam int SETS  = 1 << SET_LEN;
  localparam int WORDS = 1 << LINE_LEN;

  logic [DATA_W-1:0] data_q [SETS][WORDS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;

  // Payload arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_index][wr_offset] <= wr_data;
    end
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/ysyx_ifu_l1i.sv
// Direct-mapped L1 I-cache: hits return one cycle after acceptance, misses after a line burst refill.
// valid_o holds with stable inst_o/pc_o until next_ready; requests are refused while fence_i is high.
module ysyx_ifu_l1i
  import ysyx_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SET_LEN  = SET_LEN_DEF,
  parameter int LINE_LEN = LINE_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              fence_i,
  output logic              valid_o,
  input  logic              next_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  output logic [7:0]        arlen_o,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_LO = LINE_LEN + 2;
  localparam int TAG_LO = SET_LEN + LINE_LEN + 2;
  localparam int TAG_W  = ADDR_W - TAG_LO;
  localparam logic [7:0] ARLEN = 8'((1 << LINE_LEN) - 1);

  l1i_state_e state_q, state_d;

  logic [LINE_LEN-1:0] req_off;
  logic [SET_LEN-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                unused_pc_lsb;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;

  logic                hit, accept, beat_fire, last_fire;
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_LEN-1:0] offset_q, beat_cnt;
  logic [SET_LEN-1:0]  index_q;
  logic [TAG_W-1:0]    tag_q;
  logic                fence_seen;

  assign req_off       = req_pc[IDX_LO-1:2];
  assign req_idx       = req_pc[TAG_LO-1:IDX_LO];
  assign req_tag       = req_pc[ADDR_W-1:TAG_LO];
  assign unused_pc_lsb = ^req_pc[1:0];

  assign hit       = rd_valid && (rd_tag == req_tag);
  assign accept    = req_valid && req_ready;
  assign beat_fire = (state_q == REFILL) && rvalid;
  assign last_fire = beat_fire && rlast;

  ysyx_l1i_array #(
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W),
    .SET_LEN  (SET_LEN),
    .LINE_LEN (LINE_LEN)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fence_i),
    .rd_index  (req_idx),
    .rd_offset (req_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (beat_fire),
    .wr_index  (index_q),
    .wr_offset (beat_cnt),
    .wr_data   (rdata),
    .tag_we    (last_fire),
    .wr_tag    (tag_q),
    .wr_valid  (!(fence_seen || fence_i))
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = hit ? RESP : AR;
      end
      AR: begin
        if (arready) state_d = REFILL;
      end
      REFILL: begin
        if (last_fire) state_d = RESP;
      end
      RESP: begin
        if (next_ready) begin
          if (accept) state_d = hit ? RESP : AR;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    valid_o   = 1'b0;
    arvalid_o = 1'b0;
    case (state_q)
      IDLE: req_ready = !fence_i;
      AR:   arvalid_o = 1'b1;
      RESP: begin
        valid_o   = 1'b1;
        req_ready = next_ready && !fence_i;
      end
      default: ;
    endcase
  end

  assign araddr_o = line_addr;
  assign arlen_o  = ARLEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_o     <= '0;
      pc_o       <= '0;
      line_addr  <= '0;
      offset_q   <= '0;
      index_q    <= '0;
      tag_q      <= '0;
      beat_cnt   <= '0;
      fence_seen <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (accept) begin
        pc_o       <= req_pc;
        fence_seen <= 1'b0;
        if (hit) begin
          inst_o    <= rd_data;
          hit_cnt_o <= hit_cnt_o + 32'd1;
        end else begin
          line_addr  <= {req_pc[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
          offset_q   <= req_off;
          index_q    <= req_idx;
          tag_q      <= req_tag;
          miss_cnt_o <= miss_cnt_o + 32'd1;
        end
      end else if (fence_i && (state_q == AR || state_q == REFILL)) begin
        // The line being fetched may predate the fence, so it must not be marked valid.
        fence_seen <= 1'b1;
      end
      if (beat_fire) begin
        beat_cnt <= rlast ? '0 : beat_cnt + LINE_LEN'(1);
        if (beat_cnt == offset_q) inst_o <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_l1i.sv
// Directed bench for ysyx_ifu_l1i: a bus responder and request driver feed a scoreboard,
// while a negedge monitor pops expected (inst, pc) pairs on every accepted output.
module tb_ysyx_ifu_l1i;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, fence_i, valid_o, next_ready;
  logic [31:0] req_pc, inst_o, pc_o, araddr_o, rdata, hit_cnt_o, miss_cnt_o;
  logic        arvalid_o, arready, rvalid, rlast;
  logic [7:0]  arlen_o;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_ifu_l1i dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .fence_i    (fence_i),
    .valid_o    (valid_o),
    .next_ready (next_ready),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .araddr_o   (araddr_o),
    .arvalid_o  (arvalid_o),
    .arlen_o    (arlen_o),
    .arready    (arready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rlast      (rlast),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o && next_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got inst %h pc %h expected none", inst_o, pc_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_inst", inst_o, e.inst);
        check("sb_pc", pc_o, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] pc, input logic [31:0] inst, input bit push);
    int n = 0;
    if (push) sb_q.push_back({inst, pc});
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Waits for the read request, holds it off a cycle with a stray rvalid, then grants it.
  task automatic wait_ar(input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    while (!arvalid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("arvalid", {31'd0, arvalid_o}, 32'd1);
    check("araddr", araddr_o, addr);
    check("arlen", {24'd0, arlen_o}, 32'd3);
    step();
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("araddr_hold", araddr_o, addr);
    check("arvalid_hold", {31'd0, arvalid_o}, 32'd1);
    step();
    rvalid  = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
  endtask

  task automatic beats(input logic [3:0][31:0] b, input int n, input int fence_beat, input bit do_last);
    for (int i = 0; i < n; i++) begin
      rvalid  = 1'b1;
      rdata   = b[i];
      rlast   = do_last && (i == n - 1);
      fence_i = (i == fence_beat);
      step();
    end
    rvalid  = 1'b0;
    rlast   = 1'b0;
    fence_i = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_pc     = '0;
    fence_i    = 1'b0;
    next_ready = 1'b1;
    arready    = 1'b0;
    rdata      = '0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_hit", hit_cnt_o, 32'd0);
    check("rst_miss", miss_cnt_o, 32'd0);
    @(posedge clk);
    step();
    rst_n = 1'b1;

    // Cold miss, critical word is beat 1.
    send_req(32'h8000_0004, 32'h22, 1);
    wait_ar(32'h8000_0000);
    beats({32'h44, 32'h33, 32'h22, 32'h11}, 4, -1, 1);
    @(negedge clk);
    check("t1_miss", miss_cnt_o, 32'd1);
    check("t1_inst", inst_o, 32'h22);
    step();
    @(negedge clk);
    check("t2_idle_valid", {31'd0, valid_o}, 32'd0);
    step();

    // Hit from IDLE: one-cycle latency, no bus traffic.
    send_req(32'h8000_000C, 32'h44, 1);
    @(negedge clk);
    check("t2_valid_lat", {31'd0, valid_o}, 32'd1);
    check("t2_no_ar", {31'd0, arvalid_o}, 32'd0);
    check("t2_hit", hit_cnt_o, 32'd1);
    step();
    @(negedge clk);
    check("t2_no_ar2", {31'd0, arvalid_o}, 32'd0);
    step();

    // Same index, different tag evicts; the old line then misses again.
    send_req(32'h8000_0084, 32'hA1, 1);
    wait_ar(32'h8000_0080);
    beats({32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4, -1, 1);
    send_req(32'h8000_0004, 32'h22, 1);
    wait_ar(32'h8000_0000);
    beats({32'h44, 32'h33, 32'h22, 32'h11}, 4, -1, 1);
    @(negedge clk);
    check("t3_miss", miss_cnt_o, 32'd3);
    step();

    // fence_i during beat 2: instruction delivered, line left invalid.
    send_req(32'h8000_0018, 32'hB2, 1);
    wait_ar(32'h8000_0010);
    beats({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4, 2, 1);
    send_req(32'h8000_0018, 32'hB2, 1);
    wait_ar(32'h8000_0010);
    beats({32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4, -1, 1);
    @(negedge clk);
    check("t4_miss", miss_cnt_o, 32'd5);
    step();

    // Stall in RESP for 5 cycles, then back-to-back hits.
    send_req(32'h8000_001C, 32'hB3, 1);
    next_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_valid", {31'd0, valid_o}, 32'd1);
      check("t5_stall_inst", inst_o, 32'hB3);
      check("t5_stall_pc", pc_o, 32'h8000_001C);
      step();
    end
    next_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_pc = 32'h8000_0010 + i * 4;
      sb_q.push_back({32'hB0 + i, req_pc});
      @(negedge clk);
      check("t5_b2b_ready", {31'd0, req_ready}, 32'd1);
      check("t5_b2b_valid", {31'd0, valid_o}, 32'd1);
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("t5_last_valid", {31'd0, valid_o}, 32'd1);
    check("t5_hit", hit_cnt_o, 32'd6);
    step();

    // Early rlast after two beats: line still marked valid.
    send_req(32'h8000_0024, 32'hD1, 1);
    wait_ar(32'h8000_0020);
    beats({32'h0, 32'h0, 32'hD1, 32'hD0}, 2, -1, 1);
    send_req(32'h8000_0020, 32'hD0, 1);
    @(negedge clk);
    check("t6_hit", hit_cnt_o, 32'd7);
    check("t6_miss", miss_cnt_o, 32'd6);
    step();

    // Asynchronous reset in the middle of a refill.
    send_req(32'h8000_0040, 32'h0, 0);
    wait_ar(32'h8000_0040);
    beats({32'hC3, 32'hC2, 32'hC1, 32'hC0}, 2, -1, 0);
    @(negedge clk);
    check("t7_pre_inst", inst_o, 32'hC0);
    check("t7_pre_pc", pc_o, 32'h8000_0040);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_inst", inst_o, 32'd0);
    check("t7_rst_pc", pc_o, 32'd0);
    check("t7_rst_miss", miss_cnt_o, 32'd0);
    check("t7_rst_hit", hit_cnt_o, 32'd0);
    check("t7_rst_arvalid", {31'd0, arvalid_o}, 32'd0);
    check("t7_rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("t7_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    step();
    rst_n = 1'b1;
    send_req(32'h8000_0004, 32'h22, 1);
    wait_ar(32'h8000_0000);
    beats({32'h44, 32'h33, 32'h22, 32'h11}, 4, -1, 1);
    @(negedge clk);
    check("t7_post_miss", miss_cnt_o, 32'd1);
    check("t7_post_hit", hit_cnt_o, 32'd0);
    step();
    step();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu_l1i.md
YSYX_IFU_L1I -- requirements
Module: ysyx_ifu_l1i

Interface
REQ-001 SHALL have parameters, one per line:
- ADDR_W, default 32, address width.
- DATA_W, default 32, instruction/bus word width.
- SET_LEN, default 3, log2 of the set count (8 sets, direct-mapped).
- LINE_LEN, default 2, log2 of words per line (4 words).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  the one clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_pc  in  ADDR_W  fetch address, word-aligned.
- fence_i  in  1  invalidate all lines.
- valid_o  out  1  instruction valid to the next stage.
- next_ready  in  1  next stage accepts.
- inst_o  out  DATA_W  instruction.
- pc_o  out  ADDR_W  pc of inst_o.
- araddr_o  out  ADDR_W  burst read address.
- arvalid_o  out  1  read request valid.
- arlen_o  out  8  burst beats minus 1.
- arready  in  1  bus accepts the request.
- rdata  in  DATA_W  read beat data.
- rvalid  in  1  read beat valid.
- rlast  in  1  last beat.
- hit_cnt_o  out  32  hit counter.
- miss_cnt_o  out  32  miss counter.

Function
REQ-003 SHALL decode req_pc as follows: offset = req_pc[LINE_LEN+1:2], index = req_pc[SET_LEN+LINE_LEN+1:LINE_LEN+2], tag = the remaining upper bits.
REQ-004 SHALL implement a 4-state FSM: IDLE, AR, REFILL, RESP.
REQ-005 SHALL drive req_ready = (IDLE | (RESP & next_ready)) & !fence_i.
REQ-006 SHALL classify an accepted request as a hit when valid[index] is set and tag_arr[index]==tag; a hit SHALL load inst_o/pc_o and enter RESP next cycle (1-cycle latency).
REQ-007 SHALL send an accepted miss to AR, latching pc and the line base address (offset bits zeroed).
REQ-008 SHALL hold arvalid_o=1 in AR with araddr_o = line base and arlen_o = 2^LINE_LEN-1; araddr_o/arlen_o SHALL remain stable until arready, then the FSM moves to REFILL.
REQ-009 SHALL, in REFILL, write each rvalid beat to word beat_cnt of the line (beat_cnt starts at 0 and increments per beat), and capture the beat whose beat_cnt equals the latched offset into inst_o.
REQ-010 SHALL, on rvalid&rlast, write tag, set valid[index] and enter RESP; valid SHALL NOT be set if fence_i was seen during this refill.
REQ-011 SHALL hold valid_o=1 with inst_o/pc_o stable in RESP until next_ready.
REQ-012 SHALL, in RESP with next_ready: go to the hit-RESP or AR path if a new request is accepted the same cycle, otherwise go to IDLE (back-to-back hits give one instruction per cycle).
REQ-013 SHALL make fence_i clear all valid bits at the next edge in any state; an in-progress refill SHALL complete its bus burst and still deliver its instruction (REQ-010).
REQ-014 SHALL increment hit_cnt_o per accepted hit and miss_cnt_o per accepted miss; both SHALL wrap modulo 2^32.
REQ-015 SHALL ignore rvalid outside REFILL; an early rlast SHALL end the refill and leave words not yet written undefined, with valid still set.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously set: state=IDLE, all valid bits=0, valid_o=0, arvalid_o=0, inst_o=0, pc_o=0, counters=0, beat_cnt=0.
REQ-017 SHALL abandon any outstanding burst on reset; bus-side draining is the interconnect's responsibility.
REQ-018 SHALL NOT reset the data and tag arrays.

Structure
REQ-019 SHALL place the FSM state encoding (IDLE/AR/REFILL/RESP) and the default parameter constants in the shared package ysyx_pkg.
REQ-020 SHALL implement tag/data/valid storage in one sub-module, ysyx_l1i_array (1 read port, 1 write port, flash-clear of valid).

Verification (SET_LEN=3, LINE_LEN=2)
REQ-021 SHALL cover: cold fetch 0x8000_0004 -> araddr_o=0x8000_0000, arlen_o=3; beats 0x11,0x22,0x33,0x44 -> inst_o=0x22, pc_o=0x8000_0004, miss_cnt_o=1.
REQ-022 SHALL cover: then fetch 0x8000_000C -> valid_o one cycle after acceptance, inst_o=0x44, arvalid_o never asserted, hit_cnt_o=1.
REQ-023 SHALL cover: fetch 0x8000_0084 (same index 0, different tag) -> miss and refill; a later 0x8000_0004 misses again.
REQ-024 SHALL cover: fence_i pulse during beat 2 of a refill -> instruction still delivered, and the same address then misses.
REQ-025 SHALL cover: next_ready=0 for 5 cycles in RESP -> valid_o, inst_o and pc_o stable; then back-to-back hits with next_ready=1 -> one valid_o per cycle.
REQ-026 SHALL cover: rst_n low mid-REFILL -> outputs take reset values immediately (asynchronously); a fetch after release misses.
